// File: rtl/cmem_pkg.sv
// Shared constants and address-map helpers for the cmem_evt register/event block.
package cmem_pkg;

    // RASP_IRQ behaviour selection
    localparam int IRQ_TOGGLE = 0;
    localparam int IRQ_LEVEL  = 1;

    // Number of plain data registers below the four event/enable registers
    function automatic int data_words(input int aw);
        return (1 << aw) - 4;
    endfunction

    // Last data register, mirrored continuously on cfg
    function automatic int cfg_addr(input int aw);
        return (1 << aw) - 5;
    endfunction

    function automatic int r_evt_addr(input int aw);
        return (1 << aw) - 4;
    endfunction

    function automatic int r_en_addr(input int aw);
        return (1 << aw) - 3;
    endfunction

    function automatic int a_evt_addr(input int aw);
        return (1 << aw) - 2;
    endfunction

    function automatic int a_en_addr(input int aw);
        return (1 << aw) - 1;
    endfunction

endpackage

// File: rtl/cmem_evt_if.sv
// CP and SPI access ports of the shared register block.
interface cmem_evt_if #(
    parameter int DW = 4,
    parameter int AW = 4
) ();
    logic          spi_read;
    logic          spi_write;
    logic [AW-1:0] spi_address;
    logic [DW-1:0] spi_out_cmem_in;
    logic [DW-1:0] spi_in_cmem_out;

    logic          cp_read;
    logic          cp_write;
    logic [AW-1:0] cp_address;
    logic [DW-1:0] cp_out_cmem_in;
    logic [DW-1:0] cp_in_cmem_out;

    // Requesting side: issues strobes, receives read data
    modport master (
        output spi_read, spi_write, spi_address, spi_out_cmem_in,
        output cp_read, cp_write, cp_address, cp_out_cmem_in,
        input  spi_in_cmem_out, cp_in_cmem_out
    );

    // Register block side
    modport slave (
        input  spi_read, spi_write, spi_address, spi_out_cmem_in,
        input  cp_read, cp_write, cp_address, cp_out_cmem_in,
        output spi_in_cmem_out, cp_in_cmem_out
    );
endinterface

// File: rtl/cmem_evt_chan.sv
// One event/enable channel: OR-set events with read-clear, an enable
// register, the forwarded read view and the trigger computed on next-state.
module cmem_evt_chan
    import cmem_pkg::*;
#(
    parameter int            DW     = 4,
    parameter logic [DW-1:0] EN_RST = '0
) (
    input  logic          clk200,
    input  logic          reset_n,
    input  logic          set_we,
    input  logic [DW-1:0] set_data,
    input  logic          rd_clr,
    input  logic          en_we,
    input  logic [DW-1:0] en_data,
    output logic [DW-1:0] evt_fwd,
    output logic [DW-1:0] en_q,
    output logic          trig
);

    logic [DW-1:0] evt_q;
    logic [DW-1:0] evt_next;
    logic [DW-1:0] en_next;

    // A read sees bits being set this cycle; the clear then drops them too
    assign evt_fwd  = evt_q | (set_we ? set_data : '0);
    assign evt_next = rd_clr ? '0 : evt_fwd;
    assign en_next  = en_we ? en_data : en_q;
    assign trig     = |(evt_next & en_next);

    // Event and enable state
    always_ff @(posedge clk200 or negedge reset_n) begin
        if (!reset_n) begin
            evt_q <= '0;
            en_q  <= EN_RST;
        end else begin
            evt_q <= evt_next;
            en_q  <= en_next;
        end
    end

endmodule

// File: rtl/cmem_evt.sv
// Shared register file with CP->Pi (R) and Pi->CP (A) event channels.
// R raises RASP_IRQ (toggle or level); A pulls AMI_INT2_n low with a
// runaway timeout that blocks the interrupt until the CP acknowledges.
module cmem_evt
    import cmem_pkg::*;
#(
    parameter int          DW          = 4,
    parameter int          AW          = 4,
    parameter int          R_IRQ_LEVEL = IRQ_TOGGLE,
    parameter int          R_EN_RST    = 7,
    parameter int          A_EN_RST    = 3,
    parameter int unsigned A_TMO       = (1 << 28) - 1
) (
    input  logic         clk200,
    input  logic         reset_n,
    cmem_evt_if.slave    bus,
    output logic [DW-1:0] cfg,
    output logic          RASP_IRQ,
    output wire           AMI_INT2_n
);

    localparam int NDATA = data_words(AW);
    localparam int CW    = $clog2(A_TMO + 1);

    localparam logic [AW-1:0] R_EVT_A = AW'(r_evt_addr(AW));
    localparam logic [AW-1:0] R_EN_A  = AW'(r_en_addr(AW));
    localparam logic [AW-1:0] A_EVT_A = AW'(a_evt_addr(AW));
    localparam logic [AW-1:0] A_EN_A  = AW'(a_en_addr(AW));
    localparam logic [CW-1:0] TMO     = CW'(A_TMO);

    logic [DW-1:0] mem [NDATA];
    logic [DW-1:0] spi_rd_q, cp_rd_q;
    logic [DW-1:0] spi_rd_val, cp_rd_val;

    logic          r_set_we, r_clr, r_en_we, r_trig;
    logic          a_set_we, a_clr, a_en_we, a_trig;
    logic [DW-1:0] r_fwd, r_en, a_fwd, a_en;

    logic          armed;
    logic          irq_q;
    logic          drive_q;
    logic          blocked;
    logic [CW-1:0] tmo_cnt;

    // Timeout counter holds once it reaches the limit
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == TMO) ? v : v + CW'(1);
    endfunction

    // Ownership decode: CP owns R_EVT set and A_EN, SPI owns R_EN and A_EVT set
    assign r_set_we = bus.cp_write  && (bus.cp_address  == R_EVT_A);
    assign r_clr    = bus.spi_read  && (bus.spi_address == R_EVT_A);
    assign r_en_we  = bus.spi_write && (bus.spi_address == R_EN_A);
    assign a_set_we = bus.spi_write && (bus.spi_address == A_EVT_A);
    assign a_clr    = bus.cp_read   && (bus.cp_address  == A_EVT_A);
    assign a_en_we  = bus.cp_write  && (bus.cp_address  == A_EN_A);

    cmem_evt_chan #(.DW(DW), .EN_RST(DW'(R_EN_RST))) u_r_chan (
        .clk200   (clk200),
        .reset_n  (reset_n),
        .set_we   (r_set_we),
        .set_data (bus.cp_out_cmem_in),
        .rd_clr   (r_clr),
        .en_we    (r_en_we),
        .en_data  (bus.spi_out_cmem_in),
        .evt_fwd  (r_fwd),
        .en_q     (r_en),
        .trig     (r_trig)
    );

    cmem_evt_chan #(.DW(DW), .EN_RST(DW'(A_EN_RST))) u_a_chan (
        .clk200   (clk200),
        .reset_n  (reset_n),
        .set_we   (a_set_we),
        .set_data (bus.spi_out_cmem_in),
        .rd_clr   (a_clr),
        .en_we    (a_en_we),
        .en_data  (bus.cp_out_cmem_in),
        .evt_fwd  (a_fwd),
        .en_q     (a_en),
        .trig     (a_trig)
    );

    // Data registers are written from the CP side only
    always_ff @(posedge clk200 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NDATA; i++) mem[i] <= '0;
        end else if (bus.cp_write && (bus.cp_address < R_EVT_A)) begin
            mem[bus.cp_address] <= bus.cp_out_cmem_in;
        end
    end

    assign cfg = mem[cfg_addr(AW)];

    // SPI read view: data, R_EVT (forwarded) and R_EN; anything else reads 0
    always_comb begin
        spi_rd_val = '0;
        if (bus.spi_address < R_EVT_A)       spi_rd_val = mem[bus.spi_address];
        else if (bus.spi_address == R_EVT_A) spi_rd_val = r_fwd;
        else if (bus.spi_address == R_EN_A)  spi_rd_val = r_en;
    end

    // CP read view: data, A_EVT (forwarded) and A_EN; anything else reads 0
    always_comb begin
        cp_rd_val = '0;
        if (bus.cp_address < R_EVT_A)       cp_rd_val = mem[bus.cp_address];
        else if (bus.cp_address == A_EVT_A) cp_rd_val = a_fwd;
        else if (bus.cp_address == A_EN_A)  cp_rd_val = a_en;
    end

    // Read data registers hold until the next read on the same port
    always_ff @(posedge clk200 or negedge reset_n) begin
        if (!reset_n) begin
            spi_rd_q <= '0;
            cp_rd_q  <= '0;
        end else begin
            if (bus.spi_read) spi_rd_q <= spi_rd_val;
            if (bus.cp_read)  cp_rd_q  <= cp_rd_val;
        end
    end

    assign bus.spi_in_cmem_out = spi_rd_q;
    assign bus.cp_in_cmem_out  = cp_rd_q;

    // R channel: level follows the trigger, or toggles once per arm
    always_ff @(posedge clk200 or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
            armed <= 1'b1;
        end else if (R_IRQ_LEVEL == IRQ_LEVEL) begin
            irq_q <= r_trig;
        end else if (r_clr) begin
            armed <= 1'b1;
        end else if (r_trig && armed) begin
            irq_q <= ~irq_q;
            armed <= 1'b0;
        end
    end

    assign RASP_IRQ = irq_q;

    // A channel: drive INT2 unless blocked by a runaway timeout; CP ack clears
    always_ff @(posedge clk200 or negedge reset_n) begin
        if (!reset_n) begin
            drive_q <= 1'b0;
            blocked <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            drive_q <= a_trig && !blocked;
            if (a_clr) begin
                tmo_cnt <= '0;
                blocked <= 1'b0;
            end else begin
                if (drive_q)         tmo_cnt <= sat_inc(tmo_cnt);
                if (tmo_cnt == TMO)  blocked <= 1'b1;
            end
        end
    end

    assign AMI_INT2_n = drive_q ? 1'b0 : 1'bz;

endmodule

// File: doc/cmem_evt.md
# cmem_evt

Parametrised successor of the A314 shared-register/event block. It provides a register file written by the Amiga CP side and readable by both the CP and SPI ports. It also provides two event/enable channels: R (CP→Pi) and A (Pi→CP). R drives RASP_IRQ in toggle or level mode. A drives the open-drain AMI_INT2_n with a runaway-interrupt block timeout. Unlike its predecessor, it has an asynchronous reset and generic widths and depth.

## Interface
- DW, 4, data width of every register and port data bus
- AW, 4, address width; 2^AW registers; top four addresses are event registers
- R_IRQ_LEVEL, 0, 0 = RASP_IRQ toggles per armed trigger; 1 = RASP_IRQ is registered level of trigger
- R_EN_RST, 7, reset value of R enable
- A_EN_RST, 3, reset value of A enable
- A_TMO, 2^28-1, cycles of continuous INT2 drive before A is blocked (≥1)
- clk200  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- spi_read / spi_write  in  1  SPI-side strobes, one cycle each
- spi_address  in  AW  SPI register address
- spi_out_cmem_in  in  DW  SPI write data
- spi_in_cmem_out  out  DW  SPI read data, registered
- cp_read / cp_write  in  1  CP-side strobes
- cp_address  in  AW  CP register address
- cp_out_cmem_in  in  DW  CP write data
- cp_in_cmem_out  out  DW  CP read data, registered
- cfg  out  DW  continuous copy of register 2^AW-5
- RASP_IRQ  out  1  Pi interrupt
- AMI_INT2_n  out  1  driven 0 when asserting, else high-Z

## Operation
- Address map (T = 2^AW): 0..T-5 data; T-4 R_EVT; T-3 R_EN; T-2 A_EVT; T-1 A_EN.
- Data registers: written only by cp_write; SPI writes to them are ignored. Both ports read them.
- Event-register ownership:
  - R_EVT: CP write ORs data in. SPI read returns the forwarded value (events | same-cycle CP write bits), then clears.
  - R_EN: SPI write.
  - A_EVT: SPI write ORs data in. CP read returns the forwarded value, then clears.
  - A_EN: CP write.
  - Non-owner reads of event/enable registers return 0. CP reads R_EN and SPI reads A_EN as 0.
- Read-clear beats a same-cycle OR-set: the set bits are returned, not retained.
- Trigger: r_trig = (R_EVT_next & R_EN_next) ≠ 0, where _next includes same-cycle writes. a_trig is formed the same way for A.
- R toggle mode: armed is set at reset. An armed trigger toggles RASP_IRQ and clears armed. An SPI read of R_EVT re-arms, and wins over a same-cycle trigger.
- R level mode: RASP_IRQ ← r_trig each cycle.
- A channel:
  - drive ← a_trig && !blocked.
  - Timeout counter clears on CP read of A_EVT, increments while drive = 1, and saturates at A_TMO.
  - blocked sets the cycle after the counter equals A_TMO. A CP read of A_EVT clears blocked and the counter.

## Timing
- Read data is valid the cycle after the strobe and holds until the next read on that port.
- RASP_IRQ and drive register one cycle after the causing write.
- Once blocked, AMI_INT2_n releases one cycle after blocked sets.
- Reset values:
  - outputs: spi_in/cp_in = 0, RASP_IRQ = 0, AMI_INT2_n = Z, cfg = 0
  - internal: data = 0, events = 0, R_EN = R_EN_RST, A_EN = A_EN_RST, armed = 1, counter = 0, blocked = 0
- Reset asserted mid-drive releases INT2 immediately (asynchronous).
- Simultaneous CP and SPI access to the same address is legal. Each port follows its own ownership rule.

## Structure
- Package cmem_pkg holds:
  - address-offset functions (r_evt_addr(AW) etc.)
  - IRQ mode constants
- Sub-module cmem_evt_chan is instantiated twice (R, A). It contains: events register with OR-set/read-clear, enable register, forwarded read value, and trigger output. The top adds toggle/arm logic for R and timeout/block logic for A.

## Test plan
- Reset defaults: after reset, CP reads R_EN → 0 and A_EN → 3; SPI reads R_EN → 7 and A_EN → 0; RASP_IRQ = 0; INT2 = Z.
- R toggle: CP writes R_EVT = 4'b0001 → RASP_IRQ toggles to 1. A second CP write of 0010 → no change. SPI reads R_EVT → 4'b0011, re-arms, and since events are now 0, RASP_IRQ stays 1.
- Same-cycle race: CP writes R_EVT = 0100 in the same cycle as an SPI read → read returns 0100, R_EVT = 0 afterwards, armed = 1.
- A block: SPI writes A_EVT = 0001 → INT2 low one cycle later. With A_TMO = 8, INT2 releases after 8 drive cycles plus 2. CP reads A_EVT → 0001 and block clears; INT2 stays Z because events are 0.
- Level mode (R_IRQ_LEVEL = 1): SPI writes R_EN = 0 → RASP_IRQ drops the next cycle despite pending events.
- Data and cfg: CP writes address 11 = 0x9 → cfg = 0x9; SPI reads address 11 → 0x9; SPI write to address 3 → no effect.
